// File: rtl/uart_tx_word_arbiter_if.sv
// Word-request and uart_tx byte handshake bundle for uart_tx_word_arbiter.
// master: requesters + uart_tx side; slave: the arbiter itself.
interface uart_tx_word_arbiter_if #(
    parameter int NUM_REQ      = 2,
    parameter int BUS_WIDTH    = 32,
    parameter int PAYLOAD_BITS = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req_i;
    logic [NUM_REQ*BUS_WIDTH-1:0] word_i;
    logic [NUM_REQ-1:0]           gnt_o;
    logic                         busy_o;
    logic [ID_W-1:0]              cur_id_o;
    logic                         tx_en_o;
    logic [PAYLOAD_BITS-1:0]      tx_data_o;
    logic                         tx_busy_i;

    modport master (
        output req_i,
        output word_i,
        output tx_busy_i,
        input  gnt_o,
        input  busy_o,
        input  cur_id_o,
        input  tx_en_o,
        input  tx_data_o
    );

    modport slave (
        input  req_i,
        input  word_i,
        input  tx_busy_i,
        output gnt_o,
        output busy_o,
        output cur_id_o,
        output tx_en_o,
        output tx_data_o
    );
endinterface

// File: rtl/uart_tx_word_arbiter.sv
// Shares one byte-wide uart_tx between NUM_REQ word requesters.
// Round-robin, word granular; word sent MSB byte first via en/busy.
// Ports: clk, rst_n (sync, active-low), bus (uart_tx_word_arbiter_if.slave):
//   req_i/word_i/gnt_o requester side, busy_o/cur_id_o status,
//   tx_en_o/tx_data_o/tx_busy_i to the uart_tx instance.
// Build option: define UART_ARB_FIXED_PRIO_EN for fixed lowest-index
// priority (requester 0 may starve others; no rotating pointer).
module uart_tx_word_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int BUS_WIDTH    = 32,
    parameter int WORD_SIZE_BY = 4,
    parameter int PAYLOAD_BITS = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    uart_tx_word_arbiter_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (WORD_SIZE_BY > 1) ? $clog2(WORD_SIZE_BY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GUARD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [BUS_WIDTH-1:0]   word_buf;
    logic [CNT_W-1:0]       byte_cnt;
    logic                   any_req;
    logic [ID_W-1:0]        win_id;
    logic [BUS_WIDTH-1:0]   win_word;

`ifdef UART_ARB_FIXED_PRIO_EN
    // Descending scan: the last hit is the lowest pending index.
    always_comb begin
        win_id  = '0;
        any_req = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_i[i]) begin
                win_id  = ID_W'(i);
                any_req = 1'b1;
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cand;

    // Scan offsets NUM_REQ..1 from the pointer; the last hit is the
    // one closest after the pointer, i.e. the round-robin winner.
    always_comb begin
        win_id  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (bus.req_i[cand]) begin
                win_id  = cand;
                any_req = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        win_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_word = bus.word_i[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            word_buf      <= '0;
            byte_cnt      <= '0;
            bus.gnt_o     <= '0;
            bus.busy_o    <= 1'b0;
            bus.cur_id_o  <= '0;
            bus.tx_en_o   <= 1'b0;
            bus.tx_data_o <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr        <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            bus.gnt_o   <= '0;
            bus.tx_en_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        word_buf     <= win_word;
                        bus.gnt_o    <= NUM_REQ'(1) << win_id;
                        bus.cur_id_o <= win_id;
`ifndef UART_ARB_FIXED_PRIO_EN
                        rr_ptr       <= win_id;
`endif
                        bus.busy_o   <= 1'b1;
                        byte_cnt     <= '0;
                        state        <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!bus.tx_busy_i) begin
                        bus.tx_data_o <=
                            word_buf[BUS_WIDTH-1 -: PAYLOAD_BITS];
                        bus.tx_en_o   <= 1'b1;
                        state         <= S_GUARD;
                    end
                end
                // uart_tx raises busy one cycle after en; skip that gap.
                S_GUARD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!bus.tx_busy_i) begin
                        word_buf <= word_buf << PAYLOAD_BITS;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == CNT_W'(WORD_SIZE_BY - 1)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_SEND;
                        end
                    end
                end
                // One non-busy cycle before the next arbitration.
                S_DONE: begin
                    bus.busy_o <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Bench for uart_tx_word_arbiter: table vectors plus corner sequences.
// A uart_tx timing model drives tx_busy_i; scoreboards hold bytes/grants.
module tb_uart_tx_word_arbiter;
    localparam int NR       = 2;
    localparam int BYTE_CYC = 10;

    logic clk;
    logic rst_n;

    uart_tx_word_arbiter_if #(
        .NUM_REQ(NR), .BUS_WIDTH(32), .PAYLOAD_BITS(8)
    ) bus ();

    uart_tx_word_arbiter #(
        .NUM_REQ(NR), .BUS_WIDTH(32),
        .WORD_SIZE_BY(4), .PAYLOAD_BITS(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nwords;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pcnt = 0;
    int gnt_cnt = 0;
    int last_pulse = -1;
    int ucnt = 0;
    bit stall = 0;
    int low_run = 0;
    int last_low_run = 0;
    int tb_ptr = NR - 1;
    logic [7:0] exp_bytes[$];
    int         exp_ids[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pick(int ptr, logic [1:0] r);
        int w;
        w = -1;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = NR - 1; i >= 0; i--)
            if (r[i]) w = i;
`else
        for (int i = NR; i >= 1; i--)
            if (r[(ptr + i) % NR]) w = (ptr + i) % NR;
`endif
        return w;
    endfunction

    task automatic model_grant(logic [1:0] r, logic [31:0] w0,
                               logic [31:0] w1);
        int w;
        logic [31:0] wd;
        w = pick(tb_ptr, r);
        wd = (w == 1) ? w1 : w0;
        exp_ids.push_back(w);
        for (int b = 0; b < 4; b++)
            exp_bytes.push_back(wd[31-8*b -: 8]);
        tb_ptr = w;
    endtask

    task automatic tick();
        int id;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.tx_en_o) begin
            pcnt++;
            if (last_pulse >= 0)
                chk("pulse_gap", 32'((cyc - last_pulse) >= 3), 32'd1);
            last_pulse = cyc;
            if (exp_bytes.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL byte_extra: got %h expected none",
                         bus.tx_data_o);
            end else begin
                chk("byte", 32'(bus.tx_data_o), 32'(exp_bytes.pop_front()));
            end
            ucnt = BYTE_CYC;
        end else if (ucnt > 0) begin
            ucnt--;
        end
        if (bus.gnt_o != 0) begin
            gnt_cnt++;
            last_low_run = low_run;
            if (exp_ids.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL gnt_extra: got %b expected none", bus.gnt_o);
            end else begin
                id = exp_ids.pop_front();
                chk("gnt", 32'(bus.gnt_o), 32'(1) << id);
                chk("cur_id", 32'(bus.cur_id_o), 32'(id));
            end
        end
        if (bus.busy_o) low_run = 0;
        else low_run++;
        bus.tx_busy_i = (ucnt > 0) || stall;
    endtask

    task automatic wait_idle(string tag);
        int n;
        n = 0;
        while ((exp_bytes.size() != 0 || bus.busy_o) && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, 32'(exp_bytes.size()), 32'd0);
        chk({tag, "_gnt_left"}, 32'(exp_ids.size()), 32'd0);
    endtask

    task automatic wait_uart();
        int n;
        n = 0;
        while (ucnt > 0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_pulses(int p0, int k);
        int n;
        n = 0;
        while (pcnt - p0 < k && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_gnt(int target);
        int n;
        n = 0;
        while (gnt_cnt < target && n < 3000) begin
            tick();
            n++;
        end
        chk("gnt_count", 32'(gnt_cnt), 32'(target));
    endtask

    vec_t vecs[6];

    initial begin
        int p0;
        int p1;
        int g;
        vecs[0] = '{2'b01, 32'h7700006A, 32'h0, 1};
        vecs[1] = '{2'b11, 32'h00000070, 32'h00000057, 4};
        vecs[2] = '{2'b10, 32'h0, 32'hA5C31E0F, 1};
        vecs[3] = '{2'b11, 32'hDEADBEEF, 32'h01234567, 3};
        vecs[4] = '{2'b01, 32'hFFFFFFFF, 32'h0, 2};
        vecs[5] = '{2'b10, 32'h0, 32'h80000001, 2};

        rst_n = 1'b0;
        bus.req_i = '0;
        bus.word_i = '0;
        bus.tx_busy_i = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_cur_id", 32'(bus.cur_id_o), 32'd0);
        chk("rst_tx_en", 32'(bus.tx_en_o), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single word: grant and first byte latency from idle.
        model_grant(2'b01, 32'h7700006A, 32'h0);
        bus.word_i = {32'h0, 32'h7700006A};
        bus.req_i = 2'b01;
        p0 = pcnt;
        tick();
        chk("lat_gnt", 32'(bus.gnt_o), 32'd1);
        bus.req_i = '0;
        tick();
        chk("lat_tx_en", 32'(bus.tx_en_o), 32'd1);
        chk("lat_tx_data", 32'(bus.tx_data_o), 32'h77);
        wait_idle("single");
        chk("single_pulses", 32'(pcnt - p0), 32'd4);

        foreach (vecs[v]) begin
            for (int k = 0; k < vecs[v].nwords; k++)
                model_grant(vecs[v].req, vecs[v].w0, vecs[v].w1);
            bus.word_i = {vecs[v].w1, vecs[v].w0};
            bus.req_i = vecs[v].req;
            wait_gnt(gnt_cnt + vecs[v].nwords);
            bus.req_i = '0;
            wait_idle($sformatf("vec%0d", v));
        end

        // Busy stall in SEND.
        wait_uart();
        stall = 1'b1;
        bus.tx_busy_i = 1'b1;
        model_grant(2'b10, 32'h0, 32'hCAFEF00D);
        bus.word_i = {32'hCAFEF00D, 32'h0};
        bus.req_i = 2'b10;
        g = gnt_cnt;
        tick();
        chk("stall_gnt", 32'(gnt_cnt - g), 32'd1);
        bus.req_i = '0;
        p0 = pcnt;
        repeat (50) tick();
        chk("stall_no_pulse", 32'(pcnt - p0), 32'd0);
        stall = 1'b0;
        bus.tx_busy_i = (ucnt > 0);
        tick();
        chk("stall_release", 32'(bus.tx_en_o), 32'd1);
        chk("stall_data", 32'(bus.tx_data_o), 32'hCA);
        wait_idle("stall");

        // Late request during the 2nd byte of req0's word.
        model_grant(2'b01, 32'h0BADF00D, 32'h0);
        bus.word_i = {32'h0, 32'h0BADF00D};
        bus.req_i = 2'b01;
        p0 = pcnt;
        wait_gnt(gnt_cnt + 1);
        bus.req_i = '0;
        wait_pulses(p0, 2);
        model_grant(2'b10, 32'h0, 32'h5EED1234);
        bus.word_i = {32'h5EED1234, 32'h0};
        bus.req_i = 2'b10;
        wait_gnt(gnt_cnt + 1);
        chk("late_after_4", 32'(pcnt - p0), 32'd4);
        chk("late_idle_gap", 32'(last_low_run), 32'd1);
        bus.req_i = '0;
        wait_idle("late");

        // Reset after the 2nd byte.
        exp_ids.push_back(0);
        exp_bytes.push_back(8'h13);
        exp_bytes.push_back(8'h57);
        bus.word_i = {32'h0, 32'h13579BDF};
        bus.req_i = 2'b01;
        p0 = pcnt;
        wait_gnt(gnt_cnt + 1);
        bus.req_i = '0;
        wait_pulses(p0, 2);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        chk("mid_rst_cur_id", 32'(bus.cur_id_o), 32'd0);
        chk("mid_rst_tx_en", 32'(bus.tx_en_o), 32'd0);
        chk("mid_rst_tx_data", 32'(bus.tx_data_o), 32'd0);
        p1 = pcnt;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("mid_rst_no_pulse", 32'(pcnt - p1), 32'd0);
        chk("mid_rst_bytes", 32'(exp_bytes.size()), 32'd0);
        tb_ptr = NR - 1;
        model_grant(2'b11, 32'h24681357, 32'h99999999);
        bus.word_i = {32'h99999999, 32'h24681357};
        bus.req_i = 2'b11;
        g = gnt_cnt;
        wait_gnt(g + 1);
        chk("post_rst_winner", 32'(bus.cur_id_o), 32'd0);
        bus.req_i = '0;
        wait_idle("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_word_arbiter.md
Name: uart_tx_word_arbiter

Overview:
- Shares the single byte-wide uart_tx instance in the Controller between several requesters that each emit 32-bit response words: the command responder, the memory-dump engine and the core debug channel.
- Arbitrates round-robin with word granularity and latches the winning word.
- Serialises the word MSB byte first through the uart_tx en/busy handshake.
- A word is never interleaved with bytes from another requester.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
BUS_WIDTH, 32, word width in bits
WORD_SIZE_BY, 4, bytes per word; BUS_WIDTH = 8*WORD_SIZE_BY
PAYLOAD_BITS, 8, UART byte width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_i  in  NUM_REQ  per-requester word-valid; held with word until gnt
word_i  in  NUM_REQ*BUS_WIDTH  packed words, requester k at [k*BUS_WIDTH +: BUS_WIDTH]
gnt_o  out  NUM_REQ  one-hot, one-cycle pulse: word of that requester captured
busy_o  out  1  high from capture until last byte completes
cur_id_o  out  $clog2(NUM_REQ) (min 1)  index of requester being served
tx_en_o  out  1  to uart_tx uart_tx_en, one-cycle pulse per byte
tx_data_o  out  PAYLOAD_BITS  to uart_tx uart_tx_data
tx_busy_i  in  1  from uart_tx uart_tx_busy

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - gnt_o=0, busy_o=0, cur_id_o=0, tx_en_o=0, tx_data_o=0.
  - State=IDLE, word buffer discarded, byte counter=0.
  - RR pointer=NUM_REQ-1, so requester 0 has top priority first.
- Reset mid-word: the byte in flight at uart_tx is not recalled; no further bytes are issued.
- States:
  - IDLE: if any req_i: pick the first set bit searching from pointer+1 modulo NUM_REQ. Latch its word into buffer, pulse gnt_o[k], set cur_id_o=k, pointer=k, busy_o=1, byte counter=0 -> SEND. Otherwise stay.
  - SEND: when tx_busy_i=0, drive tx_data_o=buffer[BUS_WIDTH-1 -: 8] and pulse tx_en_o for exactly one cycle -> GUARD. If tx_busy_i=1, wait in SEND.
  - GUARD: one cycle, ignore tx_busy_i, covering uart_tx's registered busy assertion -> WAIT.
  - WAIT: when tx_busy_i=0, shift buffer left by 8 and increment counter.
    - counter==WORD_SIZE_BY-1 -> DONE.
    - else -> SEND.
  - DONE: busy_o=0 -> IDLE. This gives one idle cycle between words, so arbitration happens fresh in IDLE.
- tx_data_o holds its last value between pulses.
- Latency: req_i to gnt_o is 1 cycle from IDLE. gnt_o to first tx_en_o is 1 cycle if uart_tx is idle.
- Requests raised while busy_o=1 are not granted until the next IDLE. word_i changes after capture have no effect.
- Requester may keep req_i high after gnt_o to queue its next word. It is re-granted only when no other requester is pending (round robin).
- Deasserting req_i before gnt_o withdraws the request with no side effect.
- Each word produces exactly WORD_SIZE_BY tx_en_o pulses, with at least 2 cycles between pulses.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIO_EN.
- Defined: the pointer is ignored; the lowest-index pending requester always wins. Requester 0 (command responder) can starve others. Pointer logic is removed.
- Undefined: round robin as above.

Test Plan:
- Single word: req_i=01, word_i[31:0]=0x7700006A, with a real uart_tx plus uart_rx loopback.
  - gnt_o=01 one cycle after req.
  - uart_rx receives 0x77,0x00,0x00,0x6A in order.
  - Exactly 4 tx_en_o pulses; busy_o falls after the 4th byte.
- Contention: req_i=11 held.
  - Words 0x00000070 (req0) and 0x00000057 (req1).
  - Grants alternate 0,1,0,1.
  - Byte stream 00 00 00 70 00 00 00 57 repeating, never interleaved.
- Late request: req1 raised during req0's 2nd byte.
  - No gnt_o[1] until req0's 4 bytes finish.
  - Then gnt_o[1] in the cycle after DONE.
- Busy stall: hold tx_busy_i=1 for 50 cycles while in SEND.
  - No tx_en_o pulse during the stall.
  - Pulse occurs the cycle after tx_busy_i falls.
- Reset mid-word: rst_n=0 after the 2nd byte.
  - Next cycle all outputs are 0.
  - No further tx_en_o.
  - After release, a request from requester 0 wins first.
- With UART_ARB_FIXED_PRIO_EN: req_i=11 held.
  - gnt_o=01 on every word; requester 1 never granted while req0 is held.
